gpio_int_ack: RTL and testbench
===============================

GPIO_INT_ACK -- requirements
Module: gpio_int_ack

Interface
REQ-001 SHALL have parameter CODE_W, default 4, giving the interrupt code width (1..8).
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, giving the code FIFO depth (power of two, 2..8).
REQ-003 SHALL have parameter ACK_CYC, default 2, giving the number of cycles INTA_N is held low (1..15).
REQ-004 SHALL have a single clock domain; reset is synchronous and active-high.
REQ-005 SHALL have the following ports:
- clk_50m  in  1  sole clock, rising-edge.
- rst_50m  in  1  synchronous active-high reset.
- i_intr  in  1  interrupt request from the GPIO interrupt controller.
- i_int_code  in  CODE_W  interrupt code, valid while i_intr=1.
- o_inta_n  out  1  interrupt acknowledge to the controller, active-low.
- i_csn_50m  in  1  bus chip select, active-low.
- i_wr_50m  in  1  bus write strobe.
- i_rd_50m  in  1  bus read strobe.
- i_addr_50m  in  2  bus register address.
- i_datin_50m  in  8  bus write data.
- o_datout_50m  out  8  bus read data.
- o_wr_valid  out  1  write-accepted pulse.
- o_rd_valid  out  1  read-data-valid pulse.
- o_irq_pend  out  1  high when the FIFO is non-empty.

Function
REQ-006 SHALL implement FSM states IDLE, ACK and WAIT_DROP.
REQ-007 IDLE, i_intr=1 and FIFO not full: SHALL push i_int_code into the FIFO in that cycle and go to ACK.
REQ-008 IDLE, i_intr=1 and FIFO full: SHALL stay in IDLE, push nothing and keep o_inta_n=1 (back-pressure).
REQ-009 ACK: SHALL drive o_inta_n=0 (registered) for exactly ACK_CYC cycles, starting the cycle after leaving IDLE, then go to WAIT_DROP.
REQ-010 On leaving ACK with i_intr still 1, SHALL set sticky flag ack_err.
REQ-011 WAIT_DROP: SHALL drive o_inta_n=1 and return to IDLE the cycle after i_intr is sampled 0.
REQ-012 SHALL never push more than one code per handshake; a new push requires a return to IDLE.
REQ-013 FIFO: SHALL be first-in first-out, with count 0..FIFO_DEPTH and read/write pointers that wrap modulo FIFO_DEPTH.
REQ-014 Simultaneous push and pop: SHALL perform both, leaving count unchanged.
REQ-015 Pop on empty: SHALL do nothing.
REQ-016 o_irq_pend SHALL equal (count != 0), registered.
REQ-017 A bus access SHALL be detected as a falling edge of i_csn_50m (previous 1, current 0) with i_rd_50m or i_wr_50m high; if both are high, it SHALL be treated as a read.
REQ-018 Read at addr 0: SHALL return the FIFO head, zero-extended to 8 bits, and pop it; if the FIFO is empty it SHALL return 8'h00 without popping.
REQ-019 Read at addr 1: SHALL return status {1'b0, count[2:0], 1'b0, ack_err, full, ~empty}.
REQ-020 Read at addr 2 or 3: SHALL return 8'h00.
REQ-021 Read timing: o_datout_50m SHALL be updated and o_rd_valid pulsed high for one cycle, one cycle after detection; o_datout_50m SHALL hold until the next read.
REQ-022 Write at addr 1 with i_datin_50m[2]=1: SHALL clear ack_err; all other write bits and addresses SHALL be ignored.
REQ-023 Any detected write SHALL pulse o_wr_valid for one cycle, one cycle after detection.
REQ-024 When ack_err is set and cleared in the same cycle, set SHALL win.
REQ-025 A pop caused by a read SHALL take effect in the cycle o_rd_valid is high.

Reset
REQ-026 While rst_50m=1 at a clock edge: FSM SHALL go to IDLE, FIFO SHALL be emptied (pointers and count 0), ack_err=0.
REQ-027 While rst_50m=1: o_inta_n=1, o_datout_50m=8'h00, o_wr_valid=0, o_rd_valid=0, o_irq_pend=0.
REQ-028 Reset asserted mid-handshake SHALL release o_inta_n to 1 on the next edge; the code of the in-flight handshake SHALL be lost.
REQ-029 The csn edge detector SHALL reset its previous-value register to 1.

Verification
REQ-030 Single interrupt: i_intr=1, code 4'h5; controller drops i_intr 1 cycle after o_inta_n falls -> o_inta_n low for 2 cycles, o_irq_pend=1; read addr 0 -> 8'h05, o_rd_valid 1 cycle later, o_irq_pend=0.
REQ-031 Fill FIFO: codes 1,2,3,4,5 offered back-to-back -> 4 acknowledged, 5th held with o_inta_n=1; status read = 8'b0100_0011; one pop, then code 5 is acknowledged.
REQ-032 Handshake violation: i_intr held high through ACK -> ack_err=1 (status bit2); write addr 1 data 8'h04 -> ack_err=0, o_wr_valid pulses once.
REQ-033 Pop and push in the same cycle with count=2 -> count stays 2; read order matches push order across pointer wrap.
REQ-034 Read addr 0 with FIFO empty -> 8'h00, count unchanged.
REQ-035 rst_50m asserted during ACK -> o_inta_n=1 next cycle, status reads 8'h00 after reset.

Source files
------------

// File: rtl/gpio_int_ack.sv
// rtl/gpio_int_ack.sv - GPIO interrupt acknowledge handshake with code FIFO and byte bus
// Codes are captured per handshake into a FIFO that is drained and inspected over the bus.
module gpio_int_ack #(
  parameter int CODE_W     = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int ACK_CYC    = 2
) (
  input  logic              clk_50m,
  input  logic              rst_50m,
  input  logic              i_intr,
  input  logic [CODE_W-1:0] i_int_code,
  output logic              o_inta_n,
  input  logic              i_csn_50m,
  input  logic              i_wr_50m,
  input  logic              i_rd_50m,
  input  logic [1:0]        i_addr_50m,
  input  logic [7:0]        i_datin_50m,
  output logic [7:0]        o_datout_50m,
  output logic              o_wr_valid,
  output logic              o_rd_valid,
  output logic              o_irq_pend
);

  localparam int         PTR_W    = $clog2(FIFO_DEPTH);
  localparam logic [3:0] DEPTH_C  = 4'(FIFO_DEPTH);
  localparam logic [3:0] ACK_LAST = 4'(ACK_CYC - 1);

  typedef enum logic [1:0] {IDLE, ACK, WAIT_DROP} state_t;

  state_t            state;
  logic [3:0]        ack_cnt;
  logic [CODE_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [3:0]        count;
  logic [3:0]        count_next;
  logic              ack_err;
  logic              csn_prev;

  logic       empty, full, push, pop;
  logic       bus_det, det_rd, det_wr;
  logic       ack_set, ack_clr;
  logic [7:0] head_ext;
  logic [7:0] status;
  logic [7:0] rd_data;

  assign empty   = (count == 4'd0);
  assign full    = (count == DEPTH_C);
  assign push    = (state == IDLE) && i_intr && !full;
  // Reads win over writes when both strobes are high.
  assign bus_det = csn_prev && !i_csn_50m && (i_rd_50m || i_wr_50m);
  assign det_rd  = bus_det && i_rd_50m;
  assign det_wr  = bus_det && !i_rd_50m;
  assign pop     = det_rd && (i_addr_50m == 2'd0) && !empty;
  assign ack_set = (state == ACK) && (ack_cnt == ACK_LAST) && i_intr;
  assign ack_clr = det_wr && (i_addr_50m == 2'd1) && ((i_datin_50m & 8'h04) != 8'h00);
  assign status  = {1'b0, count[2:0], 1'b0, ack_err, full, ~empty};

  always_comb begin
    head_ext               = '0;
    head_ext[CODE_W-1:0]   = mem[rd_ptr];
  end

  always_comb begin
    rd_data = 8'h00;
    case (i_addr_50m)
      2'd0:    rd_data = empty ? 8'h00 : head_ext;
      2'd1:    rd_data = status;
      default: rd_data = 8'h00;
    endcase
  end

  always_comb begin
    count_next = count;
    case ({push, pop})
      2'b10:   count_next = count + 4'd1;
      2'b01:   count_next = count - 4'd1;
      default: count_next = count;
    endcase
  end

  always_ff @(posedge clk_50m) begin
    if (rst_50m) begin
      state    <= IDLE;
      ack_cnt  <= 4'd0;
      o_inta_n <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (push) begin
            state    <= ACK;
            ack_cnt  <= 4'd0;
            o_inta_n <= 1'b0;
          end
        end
        ACK: begin
          if (ack_cnt == ACK_LAST) begin
            state    <= WAIT_DROP;
            o_inta_n <= 1'b1;
          end else begin
            ack_cnt <= ack_cnt + 4'd1;
          end
        end
        WAIT_DROP: begin
          if (!i_intr) state <= IDLE;
        end
        default: begin
          state    <= IDLE;
          o_inta_n <= 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk_50m) begin
    if (push) mem[wr_ptr] <= i_int_code;
  end

  always_ff @(posedge clk_50m) begin
    if (rst_50m) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= 4'd0;
      ack_err      <= 1'b0;
      csn_prev     <= 1'b1;
      o_datout_50m <= 8'h00;
      o_rd_valid   <= 1'b0;
      o_wr_valid   <= 1'b0;
      o_irq_pend   <= 1'b0;
    end else begin
      csn_prev   <= i_csn_50m;
      o_rd_valid <= det_rd;
      o_wr_valid <= det_wr;
      if (det_rd) o_datout_50m <= rd_data;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count      <= count_next;
      o_irq_pend <= (count_next != 4'd0);
      ack_err    <= ack_set | (ack_err & ~ack_clr);
    end
  end

endmodule

// File: tb/tb_gpio_int_ack.sv
// tb/tb_gpio_int_ack.sv - self-checking bench for gpio_int_ack
// Queue-based model of the code FIFO and error flag; the bench also plays the interrupt controller.
module tb_gpio_int_ack;

  localparam int CODE_W = 4;
  localparam int DEPTH  = 4;
  localparam int ACKC   = 2;

  logic              clk_50m = 1'b0;
  logic              rst_50m;
  logic              i_intr;
  logic [CODE_W-1:0] i_int_code;
  logic              o_inta_n;
  logic              i_csn_50m, i_wr_50m, i_rd_50m;
  logic [1:0]        i_addr_50m;
  logic [7:0]        i_datin_50m;
  logic [7:0]        o_datout_50m;
  logic              o_wr_valid, o_rd_valid, o_irq_pend;

  gpio_int_ack #(.CODE_W(CODE_W), .FIFO_DEPTH(DEPTH), .ACK_CYC(ACKC)) dut (
    .clk_50m(clk_50m), .rst_50m(rst_50m), .i_intr(i_intr), .i_int_code(i_int_code),
    .o_inta_n(o_inta_n), .i_csn_50m(i_csn_50m), .i_wr_50m(i_wr_50m), .i_rd_50m(i_rd_50m),
    .i_addr_50m(i_addr_50m), .i_datin_50m(i_datin_50m), .o_datout_50m(o_datout_50m),
    .o_wr_valid(o_wr_valid), .o_rd_valid(o_rd_valid), .o_irq_pend(o_irq_pend)
  );

  always #10 clk_50m = ~clk_50m;

  int checks = 0;
  int failures = 0;
  logic [CODE_W-1:0] q[$];
  logic err_m = 1'b0;

  task automatic tick();
    @(posedge clk_50m);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] stat_exp();
    int n;
    logic [2:0] n3;
    n  = q.size();
    n3 = n[2:0];
    return {1'b0, n3, 1'b0, err_m, (n == DEPTH), (n != 0)};
  endfunction

  function automatic logic [7:0] pop_exp();
    logic [7:0] v;
    v = 8'h00;
    if (q.size() != 0) v[CODE_W-1:0] = q.pop_front();
    return v;
  endfunction

  task automatic bus_read(input logic [1:0] a, input logic also_wr, input logic [7:0] exp,
                          input string tag);
    i_csn_50m = 1'b0; i_rd_50m = 1'b1; i_wr_50m = also_wr; i_addr_50m = a;
    i_datin_50m = 8'h04;
    tick();
    chk({tag, "_rdv"}, 32'(o_rd_valid), 32'd1);
    chk({tag, "_dat"}, 32'(o_datout_50m), 32'(exp));
    if (also_wr) chk({tag, "_nowrv"}, 32'(o_wr_valid), 32'd0);
    i_csn_50m = 1'b1; i_rd_50m = 1'b0; i_wr_50m = 1'b0;
    tick();
    chk({tag, "_rdv_end"}, 32'(o_rd_valid), 32'd0);
    chk({tag, "_hold"}, 32'(o_datout_50m), 32'(exp));
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [7:0] d, input string tag);
    i_csn_50m = 1'b0; i_wr_50m = 1'b1; i_rd_50m = 1'b0; i_addr_50m = a; i_datin_50m = d;
    tick();
    chk({tag, "_wrv"}, 32'(o_wr_valid), 32'd1);
    i_csn_50m = 1'b1; i_wr_50m = 1'b0;
    tick();
    chk({tag, "_wrv_end"}, 32'(o_wr_valid), 32'd0);
    if (a == 2'd1 && d[2]) err_m = 1'b0;
  endtask

  // Offer one interrupt; hold keeps i_intr high through the whole acknowledge.
  task automatic do_intr(input logic [CODE_W-1:0] c, input logic hold, input string tag);
    int waitc, lowc;
    i_intr = 1'b1; i_int_code = c;
    waitc = 0;
    while (o_inta_n !== 1'b0 && waitc < 20) begin tick(); waitc++; end
    chk({tag, "_ack_seen"}, 32'(waitc < 20), 32'd1);
    q.push_back(c);
    if (!hold) i_intr = 1'b0;
    lowc = 0;
    while (o_inta_n === 1'b0 && lowc < 20) begin lowc++; tick(); end
    chk({tag, "_low_cycles"}, 32'(lowc), 32'(ACKC));
    if (hold) err_m = 1'b1;
    i_intr = 1'b0;
    tick(); tick();
    chk({tag, "_irq_pend"}, 32'(o_irq_pend), 32'(q.size() != 0));
  endtask

  initial begin
    logic [7:0] e;
    int op;
    rst_50m = 1'b1; i_intr = 1'b0; i_int_code = '0; i_csn_50m = 1'b1;
    i_wr_50m = 1'b0; i_rd_50m = 1'b0; i_addr_50m = 2'd0; i_datin_50m = 8'h00;
    tick(); tick();
    chk("rst_inta", 32'(o_inta_n), 32'd1);
    chk("rst_dat", 32'(o_datout_50m), 32'd0);
    chk("rst_valids", 32'({o_wr_valid, o_rd_valid}), 32'd0);
    chk("rst_irq", 32'(o_irq_pend), 32'd0);
    rst_50m = 1'b0;
    tick();

    // Single interrupt, then drain it.
    do_intr(4'h5, 1'b0, "single");
    e = pop_exp();
    bus_read(2'd0, 1'b0, e, "single_rd");
    chk("single_irq_clr", 32'(o_irq_pend), 32'd0);

    // Empty read returns zero and leaves the FIFO alone.
    bus_read(2'd0, 1'b0, 8'h00, "empty_rd");
    bus_read(2'd1, 1'b0, stat_exp(), "empty_stat");

    // Fill, then a fifth request is back-pressured until one pop.
    for (int i = 1; i <= 4; i++) do_intr(CODE_W'(i), 1'b0, "fill");
    i_intr = 1'b1; i_int_code = 4'h5;
    begin
      int lows = 0;
      for (int k = 0; k < 6; k++) begin tick(); if (o_inta_n !== 1'b1) lows++; end
      chk("full_backpressure", 32'(lows), 32'd0);
    end
    bus_read(2'd1, 1'b0, 8'b0100_0011, "full_stat");
    chk("full_model_stat", 32'(stat_exp()), 32'h43);
    e = pop_exp();
    bus_read(2'd0, 1'b0, e, "full_pop");
    do_intr(4'h5, 1'b0, "after_pop");
    bus_read(2'd1, 1'b0, stat_exp(), "refill_stat");

    // Drain to two entries, then push and pop in the same cycle.
    e = pop_exp(); bus_read(2'd0, 1'b0, e, "drain");
    e = pop_exp(); bus_read(2'd0, 1'b0, e, "drain");
    bus_read(2'd1, 1'b0, stat_exp(), "two_stat");
    e = pop_exp();
    i_intr = 1'b1; i_int_code = 4'hA;
    i_csn_50m = 1'b0; i_rd_50m = 1'b1; i_addr_50m = 2'd0;
    tick();
    chk("simul_rdv", 32'(o_rd_valid), 32'd1);
    chk("simul_dat", 32'(o_datout_50m), 32'(e));
    chk("simul_ack", 32'(o_inta_n), 32'd0);
    i_csn_50m = 1'b1; i_rd_50m = 1'b0;
    do_intr(4'hA, 1'b0, "simul");
    bus_read(2'd1, 1'b0, stat_exp(), "simul_stat");
    chk("simul_count2", 32'(q.size()), 32'd2);

    // Handshake violation and its clearing.
    do_intr(4'h7, 1'b1, "viol");
    bus_read(2'd1, 1'b0, stat_exp(), "viol_stat");
    bus_read(2'd1, 1'b1, stat_exp(), "both_strobes");
    bus_write(2'd1, 8'hFB, "wr_nobit2");
    bus_read(2'd1, 1'b0, stat_exp(), "err_kept");
    bus_write(2'd0, 8'h04, "wr_addr0");
    bus_read(2'd1, 1'b0, stat_exp(), "err_kept2");
    bus_write(2'd1, 8'h04, "wr_clr");
    bus_read(2'd1, 1'b0, stat_exp(), "err_cleared");
    bus_read(2'd2, 1'b0, 8'h00, "addr2");
    bus_read(2'd3, 1'b0, 8'h00, "addr3");

    // Randomized traffic across pointer wraps.
    for (int n = 0; n < 60; n++) begin
      op = $urandom_range(0, 5);
      case (op)
        0, 1: if (q.size() < DEPTH)
                do_intr(CODE_W'($urandom_range(0, 15)), 1'($urandom_range(0, 3) == 0), "rnd_intr");
        2:    begin e = pop_exp(); bus_read(2'd0, 1'b0, e, "rnd_pop"); end
        3:    bus_read(2'd1, 1'b0, stat_exp(), "rnd_stat");
        4:    bus_write(2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)), "rnd_wr");
        default: bus_read(2'($urandom_range(2, 3)), 1'b0, 8'h00, "rnd_hi");
      endcase
    end

    // Reset in the middle of an acknowledge.
    i_intr = 1'b1; i_int_code = 4'h9;
    begin
      int w = 0;
      while (o_inta_n !== 1'b0 && w < 20) begin tick(); w++; end
      chk("rst_mid_ack_seen", 32'(w < 20), 32'd1);
    end
    rst_50m = 1'b1;
    tick();
    chk("rst_mid_inta", 32'(o_inta_n), 32'd1);
    chk("rst_mid_irq", 32'(o_irq_pend), 32'd0);
    chk("rst_mid_dat", 32'(o_datout_50m), 32'd0);
    rst_50m = 1'b0; i_intr = 1'b0;
    q.delete(); err_m = 1'b0;
    tick(); tick();
    bus_read(2'd1, 1'b0, 8'h00, "rst_mid_stat");
    bus_read(2'd0, 1'b0, 8'h00, "rst_mid_empty");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
